// File: rtl/polyshift_pkg.sv
// Shared types for the polyshift family: shift modes and sequencer states.
// Used by the single-word shifter and by the multi-word sequencer.
package polyshift_pkg;

   typedef enum logic [1:0] {
      LOGIC            = 2'd0,
      ARITHMETIC       = 2'd1,
      DOUBLE_PRECISION = 2'd2,
      CYCLIC           = 2'd3
   } shift_type_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FILL = 2'd2,
      DONE = 2'd3
   } seq_state_t;

endpackage

// File: rtl/polyshift_r.sv
// Single-word right shifter: LOGIC, ARITHMETIC, DOUBLE_PRECISION ({c,data}) and CYCLIC.
module polyshift_r
   import polyshift_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = 32
) (
   input  logic [WORD_WIDTH-1:0]         i_data,
   input  logic [WORD_WIDTH-1:0]         i_c,
   input  logic [$clog2(WORD_WIDTH)-1:0] i_size,
   input  logic [1:0]                    i_type,
   output logic [WORD_WIDTH-1:0]         o_result
);

   logic [WORD_WIDTH-1:0] w_upper;

   // Shift amount is below WORD_WIDTH, so the MSB of i_c never reaches the result.
   always_comb begin
      w_upper = '0;
      case (shift_type_t'(i_type))
         LOGIC:            w_upper = '0;
         ARITHMETIC:       w_upper = {WORD_WIDTH{i_data[WORD_WIDTH-1]}};
         DOUBLE_PRECISION: w_upper = i_c;
         CYCLIC:           w_upper = i_data;
         default:          w_upper = '0;
      endcase
      o_result = WORD_WIDTH'({w_upper, i_data} >> i_size);
   end

endmodule

// File: rtl/polyshift_seq_r.sv
// Multi-word right-shift sequencer: one result word per cycle through polyshift_r.
// Optional POLYSHIFT_SEQ_FILL_SKIP_EN fills the all-fill upper words in a single FILL cycle.
module polyshift_seq_r
   import polyshift_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned WORDS      = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_n_i,
   input  logic                                wr_en_i,
   input  logic [$clog2(WORDS):0]              wr_addr_i,
   input  logic [WORD_WIDTH-1:0]               wr_data_i,
   input  logic                                start_i,
   input  logic [$clog2(WORDS*WORD_WIDTH)-1:0] shift_size_i,
   input  logic [1:0]                          shift_type_i,
   input  logic [$clog2(WORDS)-1:0]            rd_addr_i,
   output logic [WORD_WIDTH-1:0]               rd_data_o,
   output logic                                busy_o,
   output logic                                done_o
);

   localparam int unsigned AW = $clog2(WORDS);
   localparam int unsigned SW = $clog2(WORD_WIDTH);
   localparam int unsigned TW = AW + SW;
   localparam int unsigned JW = AW + 2;
   localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

   logic [WORD_WIDTH-1:0] r_src [WORDS];
   logic [WORD_WIDTH-1:0] r_ext [WORDS];
   logic [WORD_WIDTH-1:0] r_res [WORDS];

   seq_state_t  r_state, w_next;
   shift_type_t r_type;
   logic [AW-1:0] r_q, r_k;
   logic [SW-1:0] r_r;

   logic [JW-1:0]         w_j0, w_j1;
   logic [WORD_WIDTH-1:0] w_lo, w_hi, w_shift, w_fill;
   logic w_start, w_wr, w_run_we, w_fill_we, w_fill_go;

   function automatic logic [WORD_WIDTH-1:0] src_word(input logic [JW-1:0] j);
      logic [WORD_WIDTH-1:0] v;
      v = r_src[j[AW-1:0]];
      if (j >= JW'(WORDS)) begin
         case (r_type)
            LOGIC:            v = '0;
            ARITHMETIC:       v = {WORD_WIDTH{r_src[LAST][WORD_WIDTH-1]}};
            DOUBLE_PRECISION: v = (j < JW'(2*WORDS)) ? r_ext[j[AW-1:0]] : '0;
            default:          v = r_src[j[AW-1:0]];
         endcase
      end
      return v;
   endfunction

   assign w_j0   = JW'(r_k) + JW'(r_q);
   assign w_j1   = w_j0 + JW'(1);
   assign w_fill = (r_type == ARITHMETIC) ? {WORD_WIDTH{r_src[LAST][WORD_WIDTH-1]}} : '0;

   always_comb begin
      w_lo = src_word(w_j0);
      w_hi = src_word(w_j1);
   end

`ifdef POLYSHIFT_SEQ_FILL_SKIP_EN
   assign w_fill_go = ((r_type == LOGIC) || (r_type == ARITHMETIC)) &&
                      (r_q != '0) && (w_j1 >= JW'(WORDS));
`else
   assign w_fill_go = 1'b0;
`endif

   polyshift_r #(
      .WORD_WIDTH (WORD_WIDTH)
   ) u_shift (
      .i_data   (w_lo),
      .i_c      (w_hi),
      .i_size   (r_r),
      .i_type   (DOUBLE_PRECISION),
      .o_result (w_shift)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_start   = 1'b0;
      w_wr      = 1'b0;
      w_run_we  = 1'b0;
      w_fill_we = 1'b0;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      case (r_state)
         IDLE: begin
            if (start_i) begin
               w_start = 1'b1;
               w_next  = RUN;
            end else if (wr_en_i) begin
               w_wr = 1'b1;
            end
         end
         RUN: begin
            busy_o   = 1'b1;
            w_run_we = 1'b1;
            if (w_fill_go)        w_next = FILL;
            else if (r_k == LAST) w_next = DONE;
         end
         FILL: begin
            busy_o    = 1'b1;
            w_fill_we = 1'b1;
            w_next    = DONE;
         end
         DONE: begin
            done_o = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int unsigned i = 0; i < WORDS; i++) begin
            r_src[i] <= '0;
            r_ext[i] <= '0;
            r_res[i] <= '0;
         end
         r_q    <= '0;
         r_r    <= '0;
         r_k    <= '0;
         r_type <= LOGIC;
      end else begin
         if (w_wr) begin
            if (wr_addr_i[AW]) r_ext[wr_addr_i[AW-1:0]] <= wr_data_i;
            else               r_src[wr_addr_i[AW-1:0]] <= wr_data_i;
         end
         if (w_start) begin
            r_q    <= shift_size_i[TW-1:SW];
            r_r    <= shift_size_i[SW-1:0];
            r_type <= shift_type_t'(shift_type_i);
            r_k    <= '0;
         end
         if (w_run_we) begin
            r_res[r_k] <= w_shift;
            r_k        <= r_k + AW'(1);
         end
         // r_k already points one past the last RUN-written word here.
         if (w_fill_we) begin
            for (int unsigned j = 0; j < WORDS; j++) begin
               if (AW'(j) >= r_k) r_res[j] <= w_fill;
            end
         end
      end
   end

   assign rd_data_o = r_res[rd_addr_i];

endmodule

// File: tb/tb_polyshift_seq_r.sv
// Bench for polyshift_seq_r (WORD_WIDTH=8, WORDS=4): vector table, protocol sequences, random vs. model.
`timescale 1ns/1ps
module tb_polyshift_seq_r;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [2:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       start = 1'b0;
   logic [4:0] size = '0;
   logic [1:0] typ = '0;
   logic [1:0] rd_addr = '0;
   logic [7:0] rd_data;
   logic       busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] src;
      logic [31:0] ext;
      int          sh;
      int          t;
      logic [31:0] exp;
   } vec_t;

   polyshift_seq_r #(
      .WORD_WIDTH (8),
      .WORDS      (4)
   ) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .wr_en_i      (wr_en),
      .wr_addr_i    (wr_addr),
      .wr_data_i    (wr_data),
      .start_i      (start),
      .shift_size_i (size),
      .shift_type_i (typ),
      .rd_addr_i    (rd_addr),
      .rd_data_o    (rd_data),
      .busy_o       (busy),
      .done_o       (done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   // Whole-operand reference: 64-bit {upper, src} shifted right, low 32 bits kept.
   function automatic logic [31:0] model(input logic [31:0] s, input logic [31:0] e,
                                         input int sh, input int t);
      logic [63:0] w;
      case (t)
         0:       w = {32'h0, s};
         1:       w = {{32{s[31]}}, s};
         2:       w = {e, s};
         default: w = {s, s};
      endcase
      w = w >> sh;
      return w[31:0];
   endfunction

   function automatic int exp_lat(input int sh, input int t);
`ifdef POLYSHIFT_SEQ_FILL_SKIP_EN
      if ((t == 0 || t == 1) && (sh / 8) > 0) return 4 - (sh / 8) + 2;
`endif
      return 5;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic write_word(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
   endtask

   task automatic load(input logic [31:0] s, input logic [31:0] e);
      logic [31:0] ss, ee;
      ss = s; ee = e;
      for (int i = 3; i >= 0; i--) begin
         write_word(3'(4 + i), ee[8*i +: 8]);
         write_word(3'(i), ss[8*i +: 8]);
      end
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic start_op(input int sh, input int t);
      @(negedge clk);
      start = 1'b1; size = 5'(sh); typ = 2'(t);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int first, output int lat, output int bc);
      lat = first; bc = 0;
      while (!done && lat < 40) begin
         if (busy) bc++;
         @(negedge clk);
         lat++;
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout: done_o not seen after %0d cycles", lat);
      end
   endtask

   task automatic read_res(output logic [31:0] v);
      v = '0;
      for (int i = 0; i < 4; i++) begin
         rd_addr = 2'(i);
         #1;
         v[8*i +: 8] = rd_data;
      end
   endtask

   initial begin
      vec_t        vecs[6];
      logic [31:0] res, s, e;
      int          lat, bc, sh, t;

      vecs[0] = '{32'h44332211, 32'h0,        12, 0, 32'h00044332};
      vecs[1] = '{32'h80FF00FF, 32'h0,         4, 1, 32'hF80FF00F};
      vecs[2] = '{32'h44332211, 32'h0,         8, 3, 32'h11443322};
      vecs[3] = '{32'h44332211, 32'h0,         0, 3, 32'h44332211};
      vecs[4] = '{32'h80000000, 32'h00000001, 31, 2, 32'h00000003};
      vecs[5] = '{32'h44332211, 32'hA5A5A5A5, 24, 0, 32'h00000044};

      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_done", 32'(done), 32'h0);
      read_res(res);
      check("reset_res", res, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         load(vecs[i].src, vecs[i].ext);
         start_op(vecs[i].sh, vecs[i].t);
         wait_done(1, lat, bc);
         check($sformatf("vec%0d_done_busy", i), 32'(busy), 32'h0);
         read_res(res);
         check($sformatf("vec%0d_res", i), res, vecs[i].exp);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].sh, vecs[i].t)));
         check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(exp_lat(vecs[i].sh, vecs[i].t) - 1));
         @(negedge clk);
         check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'h0);
      end

      // start_i and wr_en_i during RUN are ignored
      load(32'h44332211, 32'h0);
      start_op(12, 0);
      @(negedge clk);
      start = 1'b1; size = 5'd0; typ = 2'd3;
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hAA;
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      wait_done(3, lat, bc);
      read_res(res);
      check("run_ignore_res", res, 32'h00044332);
      check("run_ignore_latency", 32'(lat), 32'd5);
      @(negedge clk);
      check("run_ignore_no_restart", 32'(busy), 32'h0);
      start_op(0, 3);
      wait_done(1, lat, bc);
      read_res(res);
      check("run_ignore_src", res, 32'h44332211);

      // start wins over a concurrent write in IDLE
      @(negedge clk);
      start = 1'b1; size = 5'd8; typ = 2'd3;
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hEE;
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      wait_done(1, lat, bc);
      read_res(res);
      check("idle_concurrent_res", res, 32'h11443322);
      start_op(0, 3);
      wait_done(1, lat, bc);
      read_res(res);
      check("idle_concurrent_src", res, 32'h44332211);

      // asynchronous reset in the middle of RUN
      load(32'h44332211, 32'hDEADBEEF);
      start_op(4, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrun_reset_busy", 32'(busy), 32'h0);
      check("midrun_reset_done", 32'(done), 32'h0);
      read_res(res);
      check("midrun_reset_res", res, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      start_op(0, 3);
      wait_done(1, lat, bc);
      read_res(res);
      check("midrun_reset_src", res, 32'h0);
      start_op(16, 2);
      wait_done(1, lat, bc);
      read_res(res);
      check("midrun_reset_ext", res, 32'h0);

      for (int n = 0; n < 40; n++) begin
         s  = $urandom;
         e  = $urandom;
         sh = int'($urandom_range(0, 31));
         t  = int'($urandom_range(0, 3));
         load(s, e);
         start_op(sh, t);
         wait_done(1, lat, bc);
         read_res(res);
         check($sformatf("rand%0d_res t=%0d sh=%0d", n, t, sh), res, model(s, e, sh, t));
         check($sformatf("rand%0d_latency", n), 32'(lat), 32'(exp_lat(sh, t)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
